cdc_clear_seq: RTL
==================

CDC_CLEAR_SEQ -- requirements
Module: cdc_clear_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of the forwarded payload.
REQ-002 SHALL have parameter CLEAR_CYCLES, default 4: cycles cdc_clear_o is held high; legal range is 1 or more.
REQ-003 SHALL have parameter DRAIN_TIMEOUT, default 64: maximum number of DRAIN cycles; legal range is 1 or more.
REQ-004 SHALL have parameter SETTLE_CYCLES, default 2: post-clear quiet cycles; legal range is 1 or more.
REQ-005 SHALL have these ports, clock and reset first:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high (already decided).
- clear_req_i  in  1  request one clear sequence.
- clear_ack_o  out  1  one-cycle pulse when a sequence completes.
- busy_o  out  1  high while a sequence is in progress.
- timeout_o  out  1  last drain ended by timeout rather than by cdc_ready_i.
- up_data_i  in  DATA_WIDTH  upstream payload.
- up_valid_i  in  1  upstream valid.
- up_ready_o  out  1  upstream ready.
- cdc_data_o  out  DATA_WIDTH  payload to the clearable CDC source side.
- cdc_valid_o  out  1  valid to the CDC.
- cdc_ready_i  in  1  ready from the CDC; high means no item is in flight.
- cdc_clear_o  out  1  clear to the CDC source side.

Function
REQ-006 FSM states SHALL be IDLE, DRAIN, CLEAR and SETTLE.
REQ-007 The upstream port SHALL be gated as follows:
- cdc_data_o = up_data_i always.
- In IDLE: cdc_valid_o = up_valid_i and up_ready_o = cdc_ready_i.
- Outside IDLE: cdc_valid_o = 0 and up_ready_o = 0.
REQ-008 In IDLE, clear_req_i or pend_q high SHALL move the FSM to DRAIN next cycle, load the drain counter and clear timeout_o; a transfer in that same cycle completes normally.
REQ-009 In DRAIN, cdc_ready_i high SHALL move the FSM to CLEAR next cycle; the check applies from the first DRAIN cycle.
REQ-010 If cdc_ready_i stays low for DRAIN_TIMEOUT DRAIN cycles, the FSM SHALL move to CLEAR and set timeout_o together with that transition.
REQ-011 In CLEAR, cdc_clear_o SHALL be high for exactly CLEAR_CYCLES consecutive cycles, then the FSM SHALL move to SETTLE; cdc_clear_o SHALL be low in every other state.
REQ-012 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then the FSM SHALL return to IDLE, with clear_ack_o high for exactly the first IDLE cycle.
REQ-013 busy_o SHALL be high whenever the state is not IDLE; busy_o, cdc_clear_o and the gating SHALL decode from registered state only.
REQ-014 clear_req_i seen outside IDLE SHALL set pend_q; any number of such requests coalesce into one further sequence.
REQ-015 pend_q SHALL clear when that sequence starts; the new sequence starts on the same cycle clear_ack_o pulses.
REQ-016 A single down-counter SHALL serve DRAIN, CLEAR and SETTLE, reloaded on each state entry; its width SHALL be $clog2(max(DRAIN_TIMEOUT, CLEAR_CYCLES, SETTLE_CYCLES)+1).
REQ-017 timeout_o SHALL hold its value until the next sequence starts.
REQ-018 The bench SHALL check that cdc_valid_o and cdc_clear_o are never both high.

Reset
REQ-019 With rst_i sampled high, all of the following SHALL hold from the next cycle:
- state = IDLE;
- counter = 0, pend_q = 0;
- timeout_o = 0, clear_ack_o = 0, busy_o = 0, cdc_clear_o = 0.
REQ-020 Reset asserted during any state SHALL abort the sequence without issuing clear_ack_o; a clear_req_i seen during reset SHALL be dropped.

Structure
REQ-021 Package cdc_clear_seq_pkg SHALL hold the state enum typedef and a counter-width function.
REQ-022 The block SHALL have no sub-module: one FSM and one shared counter.

Verification (defaults; the request is at cycle 0)
REQ-023 Idle drain case: cdc_ready_i=1, one-cycle clear_req_i -> DRAIN at cycle 1, cdc_clear_o high in cycles 2-5, SETTLE in cycles 6-7, clear_ack_o at cycle 8, timeout_o=0.
REQ-024 Busy drain case: cdc_ready_i=0 until cycle 10 -> cdc_clear_o high in cycles 11-14 and clear_ack_o at cycle 17.
REQ-025 Timeout case: cdc_ready_i held at 0 -> CLEAR entered at cycle 65, timeout_o=1 from cycle 65, clear_ack_o at cycle 71, and timeout_o cleared by the next request.
REQ-026 Coalesced requests: clear_req_i pulsed at cycles 3 and 5 while busy -> exactly one extra sequence, beginning at cycle 8, and two clear_ack_o pulses total.
REQ-027 Traffic gating: up_valid_i=1 throughout, with a request at cycle 0 -> transfer completes at cycle 0, cdc_valid_o=0 and up_ready_o=0 in cycles 1-7, and traffic resumes at cycle 8.
REQ-028 Reset mid-sequence: rst_i high at cycle 3 -> from cycle 4, cdc_clear_o=0 and busy_o=0, and no clear_ack_o follows.

Source files
------------

// File: rtl/cdc_clear_seq_pkg.sv
// Shared types and sizing helpers for the CDC clear sequencer.
package cdc_clear_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        CLEAR  = 2'd2,
        SETTLE = 2'd3
    } state_t;

    // Width of the one counter shared by DRAIN, CLEAR and SETTLE.
    function automatic int cnt_width(input int drain_t, input int clear_c, input int settle_c);
        int m;
        m = drain_t;
        if (clear_c > m) m = clear_c;
        if (settle_c > m) m = settle_c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/cdc_clear_seq.sv
// Drains, clears and settles a clearable CDC source side on request, gating
// upstream traffic for the whole sequence and coalescing requests that arrive meanwhile.
module cdc_clear_seq
    import cdc_clear_seq_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int CLEAR_CYCLES  = 4,
    parameter int DRAIN_TIMEOUT = 64,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_req_i,
    output logic                  clear_ack_o,
    output logic                  busy_o,
    output logic                  timeout_o,
    input  logic [DATA_WIDTH-1:0] up_data_i,
    input  logic                  up_valid_i,
    output logic                  up_ready_o,
    output logic [DATA_WIDTH-1:0] cdc_data_o,
    output logic                  cdc_valid_o,
    input  logic                  cdc_ready_i,
    output logic                  cdc_clear_o
);

    localparam int CNT_W = cnt_width(DRAIN_TIMEOUT, CLEAR_CYCLES, SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] DRAIN_LOAD  = CNT_W'(DRAIN_TIMEOUT);
    localparam logic [CNT_W-1:0] CLEAR_LOAD  = CNT_W'(CLEAR_CYCLES);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             pend_q;
    logic             start;
    logic             cnt_last;

    assign start      = (state_q == IDLE) && (clear_req_i || pend_q);
    assign cnt_last   = (cnt_q == CNT_ONE);
    assign cdc_data_o = up_data_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Ready wins over an expiring drain count, so a late drain is not a timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = DRAIN;
            DRAIN:   if (cdc_ready_i || cnt_last) state_d = CLEAR;
            CLEAR:   if (cnt_last) state_d = SETTLE;
            SETTLE:  if (cnt_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o      = (state_q != IDLE);
        cdc_clear_o = (state_q == CLEAR);
        cdc_valid_o = (state_q == IDLE) && up_valid_i;
        up_ready_o  = (state_q == IDLE) && cdc_ready_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            timeout_o   <= 1'b0;
            clear_ack_o <= 1'b0;
        end else begin
            clear_ack_o <= (state_q == SETTLE) && cnt_last;

            // Reload on every state entry; count down while dwelling.
            if (state_d != state_q) begin
                case (state_d)
                    DRAIN:   cnt_q <= DRAIN_LOAD;
                    CLEAR:   cnt_q <= CLEAR_LOAD;
                    SETTLE:  cnt_q <= SETTLE_LOAD;
                    default: cnt_q <= '0;
                endcase
            end else if (cnt_q != '0) begin
                cnt_q <= cnt_q - CNT_ONE;
            end

            if (start)                                pend_q <= 1'b0;
            else if (clear_req_i && state_q != IDLE) pend_q <= 1'b1;

            if (start)
                timeout_o <= 1'b0;
            else if (state_q == DRAIN && !cdc_ready_i && cnt_last)
                timeout_o <= 1'b1;
        end
    end

endmodule
